piece_ctrl: RTL and testbench
=============================

# piece_ctrl

Active-piece sequencer for the Tetris datapath. Holds the falling piece's type, rotation and position, and drives the shape decoder (type, rot → four 4-bit rows). It validates every spawn, shift, rotate and gravity step against the playfield with a pipelined 4-row collision check, and hands locked pieces to the board writer. Sits between the input/gravity timers and the board RAM.

## Interface
- `BOARD_W`, 10: playfield columns (fixed by 10-bit row data)
- `BOARD_H`, 20: playfield rows
- `SPAWN_X`, 3: board column of the spawn box's leftmost column
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; **asynchronous, active-low**
- `start`  in  1  pulse; spawns the first piece when no piece is active
- `next_type`  in  3  type to spawn (0 T, 1 I, 2 O, 3 L, 4 J, 5 S, 6 Z); values 7 are treated as 0
- `cmd_left`, `cmd_right`, `cmd_rot`, `cmd_drop`  in  1  move requests, sampled only while `cmd_ready` = 1
- `grav_tick`  in  1  gravity step request, sampled only while `cmd_ready` = 1
- `brd_raddr`  out  5  board row address
- `brd_rdata`  in  10  occupied row; bit c = column c (0 = leftmost); valid 1 cycle after address
- `lock_ack`  in  1  board has written the piece and cleared lines
- `cmd_ready`  out  1  piece active and idle
- `piece_valid`  out  1  a piece is on the board
- `cur_type` out 3, `cur_rot` out 2, `cur_x` out 5 (signed), `cur_y` out 5: committed piece
- `lock_valid`  out  1  level; held until `lock_ack`
- `game_over`  out  1  sticky

## Operation
- Shape geometry: decoder row k maps to board row y+k; row bit b maps to board column x+3−b.
- States:
  - EMPTY → CHECK(spawn) on `start`.
  - ACTIVE (`cmd_ready` = 1).
  - CHECK.
  - LOCK → CHECK(spawn) on `lock_ack`.
  - OVER, exited only by reset.
- In ACTIVE, one request is taken per cycle, in priority order `grav_tick` > `cmd_drop` > `cmd_rot` > `cmd_left` > `cmd_right`. Lower-priority requests raised in the same cycle are discarded.
- Candidate values:
  - left: x−1
  - right: x+1
  - gravity/drop: y+1
  - rotate: rot+1 wrapped per type (O: always 0; S, Z: mod 2; others: mod 4)
  - spawn: `next_type`, rot 0, x = `SPAWN_X`, y = 0
- CHECK reads rows y'..y'+3. A row collides if any set shape cell meets any of these:
  - its column < 0 or > `BOARD_W`−1;
  - its row > `BOARD_H`−1;
  - it overlaps a set `brd_rdata` bit.
- Rows ≥ `BOARD_H` are not read; `brd_raddr` = 0 is issued and the data is ignored.
- Arithmetic: x candidate computed 6-bit signed, so no wrap; y candidate 6-bit unsigned.
- Result, check passes: candidate committed, state returns to ACTIVE. For a hard drop, a further y+1 check starts instead.
- Result, check fails:
  - spawn → OVER; `game_over` = 1, `piece_valid` = 0
  - gravity, or drop after at least 0 successes → LOCK; `lock_valid` = 1, committed state held
  - left/right/rot → ACTIVE unchanged
- `lock_ack` outside LOCK is ignored. In LOCK, `next_type` is sampled in the cycle `lock_ack` is seen.

## Timing
- Reset values:
  - state EMPTY
  - `cmd_ready` = 0, `piece_valid` = 0, `lock_valid` = 0, `game_over` = 0
  - `cur_*` = 0, `brd_raddr` = 0
- Request accepted at edge N: `cmd_ready` = 0 from N+1. Addresses y', y'+1, y'+2, y'+3 are driven in cycles N+1..N+4, and data is captured N+2..N+5.
- Decision at edge N+5:
  - `cur_*` updated, or `lock_valid` raised, visible N+6
  - `cmd_ready` back to 1 in N+6 if ACTIVE
- Check latency is 5 cycles; minimum request-to-request spacing is 6 cycles.
- `lock_ack` at edge M: `lock_valid` = 0 and spawn CHECK begins from M+1.
- Reset mid-CHECK or mid-LOCK aborts immediately; no partial commit.

## Configuration
- `PIECE_CTRL_HARD_DROP_EN`
  - Defined: `cmd_drop` repeats y+1 checks back-to-back (6 cycles per row) until failure, then enters LOCK.
  - Undefined: `cmd_drop` is ignored entirely, including for priority, and the drop loop logic is not built.

## Test plan
- Reset, `start` with `next_type` = 0 on an empty board → after 6 cycles `piece_valid` = 1, type 0, rot 0, x = 3, y = 0, `cmd_ready` = 1.
- I piece (rot 0, occupies box column 2) at x = −2: `cmd_left` → rejected, x stays −2; `cmd_right` → x = −1.
- O piece: `cmd_rot` → rot stays 0. S piece rot 1: `cmd_rot` → rot 0.
- T piece, row 5 full, at y = 3: `grav_tick` → `lock_valid` = 1, y = 3. `lock_ack` → new spawn from `next_type`.
- Hard drop (macro defined) of O from y = 0 on an empty board → y = 18, then `lock_valid` after 19 checks (114 cycles). Without the macro → no change.
- Row 0 columns 3..6 occupied, `start` → `game_over` = 1 and sticky; commands ignored until `rst_n` low.

Source files
------------

// File: rtl/piece_ctrl.sv
// piece_ctrl - active-piece sequencer for the Tetris datapath.
//
// Holds the falling piece (type, rotation, position) and validates every
// spawn, shift, rotate and gravity step against the playfield. Each
// candidate position is checked by a 4-row collision pass: one board row
// address per cycle, read data folded into a collision flag as it returns.
// Pieces that cannot fall further are handed to the board writer through
// lock_valid/lock_ack.
//
// Optional feature macro: PIECE_CTRL_HARD_DROP_EN
//   defined   : cmd_drop repeats y+1 checks until one fails, then locks
//   undefined : cmd_drop is ignored and the drop loop is not built
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 spawn first piece from EMPTY
//   next_type[2:0]        type to spawn (7 treated as 0)
//   cmd_left/right/rot    move requests, sampled while cmd_ready
//   cmd_drop              hard drop request (feature macro)
//   grav_tick             gravity step request
//   brd_raddr[4:0]        board row address
//   brd_rdata[W-1:0]      board row, valid one cycle after the address
//   lock_ack              board has absorbed the locked piece
//   cmd_ready             piece active and idle
//   piece_valid           a piece is on the board
//   cur_type/rot/x/y      committed piece (cur_x signed)
//   lock_valid            piece locked, held until lock_ack
//   game_over             sticky, cleared only by reset
module piece_ctrl #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20,
  parameter int SPAWN_X = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         next_type,
  input  logic               cmd_left,
  input  logic               cmd_right,
  input  logic               cmd_rot,
  input  logic               cmd_drop,
  input  logic               grav_tick,
  output logic [4:0]         brd_raddr,
  input  logic [BOARD_W-1:0] brd_rdata,
  input  logic               lock_ack,
  output logic               cmd_ready,
  output logic               piece_valid,
  output logic [2:0]         cur_type,
  output logic [1:0]         cur_rot,
  output logic signed [4:0]  cur_x,
  output logic [4:0]         cur_y,
  output logic               lock_valid,
  output logic               game_over
);

  typedef enum logic [2:0] {
    S_EMPTY,
    S_ACTIVE,
    S_CHECK,
    S_LOCK,
    S_OVER
`ifdef PIECE_CTRL_HARD_DROP_EN
    ,
    S_DROP
`endif
  } state_t;

  typedef enum logic [2:0] {
    OP_SPAWN, OP_GRAV, OP_DROP, OP_ROT, OP_LEFT, OP_RIGHT
  } op_t;

  // Shape decoder. Nibble k (from the top) is box row k; bit 3 of a nibble
  // is the leftmost box column.
  function automatic logic [15:0] pick4(input logic [1:0] r, input logic [15:0] a,
                                        input logic [15:0] b, input logic [15:0] c,
                                        input logic [15:0] d);
    case (r)
      2'd0:    return a;
      2'd1:    return b;
      2'd2:    return c;
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] shape_row(input logic [2:0] t, input logic [1:0] r,
                                           input logic [1:0] k);
    logic [15:0] sh;
    case (t)
      3'd1:    sh = pick4(r, 16'h2222, 16'h0F00, 16'h4444, 16'h00F0); // I
      3'd2:    sh = 16'h6600;                                          // O
      3'd3:    sh = pick4(r, 16'h2E00, 16'h4460, 16'h0E80, 16'hC440); // L
      3'd4:    sh = pick4(r, 16'h8E00, 16'h6440, 16'h0E20, 16'h44C0); // J
      3'd5:    sh = pick4(r, 16'h6C00, 16'h4620, 16'h6C00, 16'h4620); // S
      3'd6:    sh = pick4(r, 16'hC600, 16'h2640, 16'hC600, 16'h2640); // Z
      default: sh = pick4(r, 16'hE400, 16'h4C40, 16'h4E00, 16'h4640); // T
    endcase
    return 4'(sh >> (12 - 4 * int'(k)));
  endfunction

  state_t             state, nxt;
  op_t                op, ld_op;
  logic [2:0]         cand_type, ld_type;
  logic [1:0]         cand_rot, ld_rot;
  logic signed [5:0]  cand_x, ld_x;   // 6-bit so x-1 / x+1 never wrap
  logic [5:0]         cand_y, ld_y;
  logic [2:0]         cnt;            // address phase 0..3, decision at 4
  logic               acc;            // collision seen in earlier rows
  logic               pv;
  logic               ld, commit, row_coll, coll;
  logic [2:0]         sp_type;
  logic signed [5:0]  cur_x6;
  logic [1:0]         rot_nxt;

  assign sp_type = (next_type == 3'd7) ? 3'd0 : next_type;
  assign cur_x6  = {cur_x[4], cur_x};

  always_comb begin
    case (cur_type)
      3'd2:       rot_nxt = 2'd0;
      3'd5, 3'd6: rot_nxt = {1'b0, ~cur_rot[0]};
      default:    rot_nxt = cur_rot + 2'd1;
    endcase
  end

`ifndef PIECE_CTRL_HARD_DROP_EN
  logic unused_drop;
  assign unused_drop = cmd_drop;
`endif

  // Row being read: address for row cnt, data returns one cycle later.
  always_comb begin
    int rd_row;
    brd_raddr = '0;
    rd_row    = int'(cand_y) + int'(cnt);
    if (state == S_CHECK && cnt < 3'd4 && rd_row < BOARD_H)
      brd_raddr = 5'(rd_row);
  end

  // Collision of box row cnt-1 against the data returned this cycle.
  // Rows below the board collide on any set cell, so their (ignored)
  // data never matters.
  always_comb begin
    logic [1:0] k;
    logic [3:0] srow;
    int         row_idx;
    int         col;
    row_coll = 1'b0;
    col      = 0;
    k        = 2'(cnt - 3'd1);
    srow     = shape_row(cand_type, cand_rot, k);
    row_idx  = int'(cand_y) + int'(k);
    if (srow != 4'd0 && row_idx > BOARD_H - 1) row_coll = 1'b1;
    for (int b = 0; b < 4; b++) begin
      if (srow[b]) begin
        col = int'(cand_x) + 3 - b;
        if (col < 0 || col > BOARD_W - 1) row_coll = 1'b1;
        else
          for (int c = 0; c < BOARD_W; c++)
            if (col == c && brd_rdata[c]) row_coll = 1'b1;
      end
    end
  end

  assign coll = acc | row_coll;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_EMPTY;
    else        state <= nxt;
  end

  always_comb begin
    nxt     = state;
    ld      = 1'b0;
    ld_op   = OP_SPAWN;
    ld_type = cur_type;
    ld_rot  = cur_rot;
    ld_x    = cur_x6;
    ld_y    = {1'b0, cur_y};
    commit  = 1'b0;
    case (state)
      S_EMPTY: if (start) begin
        ld = 1'b1; ld_op = OP_SPAWN; ld_type = sp_type;
        ld_rot = 2'd0; ld_x = 6'(SPAWN_X); ld_y = 6'd0;
        nxt = S_CHECK;
      end
      S_ACTIVE: begin
        ld  = 1'b1;
        nxt = S_CHECK;
        if (grav_tick) begin
          ld_op = OP_GRAV; ld_y = {1'b0, cur_y} + 6'd1;
        end
`ifdef PIECE_CTRL_HARD_DROP_EN
        else if (cmd_drop) begin
          ld_op = OP_DROP; ld_y = {1'b0, cur_y} + 6'd1;
        end
`endif
        else if (cmd_rot) begin
          ld_op = OP_ROT; ld_rot = rot_nxt;
        end else if (cmd_left) begin
          ld_op = OP_LEFT; ld_x = cur_x6 - 6'sd1;
        end else if (cmd_right) begin
          ld_op = OP_RIGHT; ld_x = cur_x6 + 6'sd1;
        end else begin
          ld  = 1'b0;
          nxt = S_ACTIVE;
        end
      end
      S_CHECK: if (cnt == 3'd4) begin
        if (!coll) begin
          commit = 1'b1;
          nxt    = S_ACTIVE;
`ifdef PIECE_CTRL_HARD_DROP_EN
          if (op == OP_DROP) nxt = S_DROP;
`endif
        end else begin
          case (op)
            OP_SPAWN:         nxt = S_OVER;
            OP_GRAV, OP_DROP: nxt = S_LOCK;
            default:          nxt = S_ACTIVE;
          endcase
        end
      end
      S_LOCK: if (lock_ack) begin
        ld = 1'b1; ld_op = OP_SPAWN; ld_type = sp_type;
        ld_rot = 2'd0; ld_x = 6'(SPAWN_X); ld_y = 6'd0;
        nxt = S_CHECK;
      end
`ifdef PIECE_CTRL_HARD_DROP_EN
      // One idle cycle between drop rows keeps the 6-cycle cadence.
      S_DROP: begin
        ld = 1'b1; ld_op = OP_DROP; ld_y = {1'b0, cur_y} + 6'd1;
        nxt = S_CHECK;
      end
`endif
      default: nxt = state;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op        <= OP_SPAWN;
      cand_type <= '0;
      cand_rot  <= '0;
      cand_x    <= '0;
      cand_y    <= '0;
      cnt       <= '0;
      acc       <= 1'b0;
      cur_type  <= '0;
      cur_rot   <= '0;
      cur_x     <= '0;
      cur_y     <= '0;
      pv        <= 1'b0;
    end else begin
      if (ld) begin
        op        <= ld_op;
        cand_type <= ld_type;
        cand_rot  <= ld_rot;
        cand_x    <= ld_x;
        cand_y    <= ld_y;
        cnt       <= '0;
        acc       <= 1'b0;
      end else if (state == S_CHECK) begin
        cnt <= cnt + 3'd1;
        if (cnt != 3'd0) acc <= coll;
      end
      if (commit) begin
        cur_type <= cand_type;
        cur_rot  <= cand_rot;
        cur_x    <= cand_x[4:0];
        cur_y    <= cand_y[4:0];
        if (op == OP_SPAWN) pv <= 1'b1;
      end
      if (state == S_LOCK && lock_ack) pv <= 1'b0;
    end
  end

  assign cmd_ready   = (state == S_ACTIVE);
  assign lock_valid  = (state == S_LOCK);
  assign game_over   = (state == S_OVER);
  assign piece_valid = pv;

endmodule

// File: tb/tb_piece_ctrl.sv
// Directed bench for piece_ctrl: a vector table of {command, board edit,
// expected committed state} plus hand sequences for cycle timing, hard
// drop, game over and reset behaviour. A one-cycle-latency board RAM model
// answers brd_raddr.
module tb_piece_ctrl;
  logic              clk = 0, rst_n = 0, start = 0;
  logic [2:0]        next_type = 0;
  logic              cmd_left = 0, cmd_right = 0, cmd_rot = 0, cmd_drop = 0;
  logic              grav_tick = 0, lock_ack = 0;
  logic [4:0]        brd_raddr;
  logic [9:0]        brd_rdata;
  logic              cmd_ready, piece_valid, lock_valid, game_over;
  logic [2:0]        cur_type;
  logic [1:0]        cur_rot;
  logic signed [4:0] cur_x;
  logic [4:0]        cur_y;

  piece_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .next_type(next_type),
    .cmd_left(cmd_left), .cmd_right(cmd_right), .cmd_rot(cmd_rot),
    .cmd_drop(cmd_drop), .grav_tick(grav_tick), .brd_raddr(brd_raddr),
    .brd_rdata(brd_rdata), .lock_ack(lock_ack), .cmd_ready(cmd_ready),
    .piece_valid(piece_valid), .cur_type(cur_type), .cur_rot(cur_rot),
    .cur_x(cur_x), .cur_y(cur_y), .lock_valid(lock_valid),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  logic [9:0] board [0:31];
  always @(posedge clk) brd_rdata <= board[brd_raddr];

  // command bits: start, left, right, rot, grav, drop, ack
  localparam logic [6:0] ST = 7'h40, LF = 7'h20, RT = 7'h10, RO = 7'h08,
                         GR = 7'h04, DR = 7'h02, AK = 7'h01;

  typedef struct {
    logic [6:0]  cmds;
    logic [2:0]  nt;
    logic        setb;
    logic [4:0]  brow;
    logic [9:0]  bval;
    logic [18:0] exp;
  } vec_t;

  int   n_vec = 0, n_bad = 0;
  vec_t tbl[$];
  logic [18:0] act;
  assign act = {cur_type, cur_rot, cur_x, cur_y, cmd_ready, lock_valid, game_over, piece_valid};

  // expected {type, rot, x, y, cmd_ready, lock_valid, game_over, piece_valid}
  function automatic logic [18:0] st(int t, int r, int x, int y, int rdy, int lk, int ov, int pv);
    return {3'(t), 2'(r), 5'(x), 5'(y), 1'(rdy), 1'(lk), 1'(ov), 1'(pv)};
  endfunction

  function automatic vec_t mk(logic [6:0] c, int nt, int sb, int brow, int bval, logic [18:0] e);
    vec_t v;
    v.cmds = c; v.nt = 3'(nt); v.setb = 1'(sb); v.brow = 5'(brow);
    v.bval = 10'(bval); v.exp = e;
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [18:0] e);
    n_vec++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, e);
    end
  endtask

  task automatic cmpv(input string nm, input int a, input int e);
    n_vec++;
    if (a != e) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  task automatic apply(input vec_t v, input string nm);
    if (v.setb) board[v.brow] = v.bval;
    @(negedge clk);
    {start, cmd_left, cmd_right, cmd_rot, grav_tick, cmd_drop, lock_ack} = v.cmds;
    next_type = v.nt;
    @(posedge clk);
    @(negedge clk);
    {start, cmd_left, cmd_right, cmd_rot, grav_tick, cmd_drop, lock_ack} = '0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    cmp(nm, v.exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    for (int i = 0; i < 32; i++) board[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp("reset", st(0, 0, 0, 0, 0, 0, 0, 0));
    cmpv("reset_raddr", int'(brd_raddr), 0);
    rst_n = 1;

    // T piece: spawn, moves, priority, rotation cycle, gravity lock
    tbl.push_back(mk(ST, 0, 0, 0, 0, st(0, 0, 3, 0, 1, 0, 0, 1)));
    tbl.push_back(mk(RO, 0, 0, 0, 0, st(0, 1, 3, 0, 1, 0, 0, 1)));
    tbl.push_back(mk(LF, 0, 0, 0, 0, st(0, 1, 2, 0, 1, 0, 0, 1)));
    tbl.push_back(mk(RT, 0, 0, 0, 0, st(0, 1, 3, 0, 1, 0, 0, 1)));
    tbl.push_back(mk(GR, 0, 0, 0, 0, st(0, 1, 3, 1, 1, 0, 0, 1)));
    tbl.push_back(mk(GR|LF|RT|RO, 0, 0, 0, 0, st(0, 1, 3, 2, 1, 0, 0, 1)));
    tbl.push_back(mk(GR, 0, 0, 0, 0, st(0, 1, 3, 3, 1, 0, 0, 1)));
    tbl.push_back(mk(RO, 0, 0, 0, 0, st(0, 2, 3, 3, 1, 0, 0, 1)));
    tbl.push_back(mk(RO, 0, 0, 0, 0, st(0, 3, 3, 3, 1, 0, 0, 1)));
    tbl.push_back(mk(RO, 0, 0, 0, 0, st(0, 0, 3, 3, 1, 0, 0, 1)));
    tbl.push_back(mk(GR, 0, 1, 5, 10'h3FF, st(0, 0, 3, 3, 0, 1, 0, 1)));
    tbl.push_back(mk(LF, 0, 1, 5, 0, st(0, 0, 3, 3, 0, 1, 0, 1)));
    // I piece: walls on both sides
    tbl.push_back(mk(AK, 1, 0, 0, 0, st(1, 0, 3, 0, 1, 0, 0, 1)));
    for (int x = 2; x >= -2; x--) tbl.push_back(mk(LF, 0, 0, 0, 0, st(1, 0, x, 0, 1, 0, 0, 1)));
    tbl.push_back(mk(LF, 0, 0, 0, 0, st(1, 0, -2, 0, 1, 0, 0, 1)));
    for (int x = -1; x <= 7; x++) tbl.push_back(mk(RT, 0, 0, 0, 0, st(1, 0, x, 0, 1, 0, 0, 1)));
    tbl.push_back(mk(RT, 0, 0, 0, 0, st(1, 0, 7, 0, 1, 0, 0, 1)));
    tbl.push_back(mk(GR, 0, 1, 4, 10'h3FF, st(1, 0, 7, 0, 0, 1, 0, 1)));
    // O piece: rotation is a no-op
    tbl.push_back(mk(AK, 2, 1, 4, 0, st(2, 0, 3, 0, 1, 0, 0, 1)));
    tbl.push_back(mk(RO, 0, 0, 0, 0, st(2, 0, 3, 0, 1, 0, 0, 1)));

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

`ifdef PIECE_CTRL_HARD_DROP_EN
    @(negedge clk);
    cmd_drop = 1;
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    cmd_drop = 0;
    while (!lock_valid && cyc < 300) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    cmpv("drop_cycles", cyc, 114);
    cmp("drop_lock", st(2, 0, 3, 18, 0, 1, 0, 1));
`else
    apply(mk(DR, 0, 0, 0, 0, st(2, 0, 3, 0, 1, 0, 0, 1)), "drop_ignored");
    apply(mk(DR|LF, 0, 0, 0, 0, st(2, 0, 2, 0, 1, 0, 0, 1)), "drop_no_prio");
    apply(mk(RT, 0, 0, 0, 0, st(2, 0, 3, 0, 1, 0, 0, 1)), "o_right");
    apply(mk(GR, 0, 1, 2, 10'h3FF, st(2, 0, 3, 0, 0, 1, 0, 1)), "o_lock");
`endif

    // S piece: rotation wraps mod 2; then type 7 spawns as T
    apply(mk(AK, 5, 1, 2, 0, st(5, 0, 3, 0, 1, 0, 0, 1)), "s_spawn");
    apply(mk(RO, 0, 0, 0, 0, st(5, 1, 3, 0, 1, 0, 0, 1)), "s_rot1");
    apply(mk(RO, 0, 0, 0, 0, st(5, 0, 3, 0, 1, 0, 0, 1)), "s_rot0");
    apply(mk(GR, 0, 1, 2, 10'h3FF, st(5, 0, 3, 0, 0, 1, 0, 1)), "s_lock");
    apply(mk(AK, 7, 1, 2, 0, st(0, 0, 3, 0, 1, 0, 0, 1)), "type7_spawn");

    // cycle-accurate gravity check: addresses y'..y'+3, ready after 6 cycles
    @(negedge clk);
    grav_tick = 1;
    @(posedge clk);
    @(negedge clk);
    grav_tick = 0;
    cmpv("busy_n1", int'(cmd_ready), 0);
    for (int k = 0; k < 4; k++) begin
      cmpv($sformatf("raddr%0d", k), int'(brd_raddr), k + 1);
      @(posedge clk);
      @(negedge clk);
    end
    cmpv("busy_n5", int'(cmd_ready), 0);
    @(posedge clk);
    @(negedge clk);
    cmp("grav_n6", st(0, 0, 3, 1, 1, 0, 0, 1));

    // game over on blocked spawn, sticky until reset
    rst_n = 0;
    @(negedge clk);
    cmp("reset2", st(0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1;
    apply(mk(ST, 0, 1, 0, 10'h078, st(0, 0, 0, 0, 0, 0, 1, 0)), "spawn_over");
    apply(mk(ST|LF|GR|AK, 0, 0, 0, 0, st(0, 0, 0, 0, 0, 0, 1, 0)), "over_sticky");
    @(negedge clk);
    rst_n = 0;
    #1;
    cmp("over_reset", st(0, 0, 0, 0, 0, 0, 0, 0));

    // reset in the middle of a spawn check: nothing commits
    board[0] = '0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    start = 1; next_type = 1;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    cmp("reset_mid", st(0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1;
    repeat (8) @(negedge clk);
    cmp("no_commit", st(0, 0, 0, 0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
